fetch_pc_gen: RTL and testbench
===============================

# fetch_pc_gen

Fetch-stage PC generator. It owns the architectural fetch PC and drives the branch predictor lookup port. It keeps an in-order FIFO of the predictions made for in-flight instructions and checks each one against the outcome resolved in execute. On a mismatch it issues a flush and redirect, and it emits the registered update stream that trains the predictor.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC after reset (word aligned)
- FIFO_DEPTH, 4, in-flight prediction entries (power of two, 2..16)

- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- hold_i  in  1  downstream stall; PC does not advance
- pc_o  out  32  current fetch PC, to instruction memory and predictor pc_i
- pred_taken_i  in  1  predictor taken flag for pc_o (combinational, same cycle)
- pred_pc_i  in  32  predictor target for pc_o; bits [1:0] ignored, forced 00
- fetch_valid_o  out  1  instruction at pc_o is accepted into the pipe this cycle
- ex_valid_i  in  1  one instruction resolved in execute this cycle, in program order
- ex_branch_i  in  1  resolved instruction is a control-flow instruction
- ex_jump_i  in  1  resolved instruction actually redirected
- ex_pc_i  in  32  resolved instruction address
- ex_target_i  in  32  resolved redirect target
- flush_o  out  1  combinational; squash IF/ID this cycle
- bp_branch_o, bp_jump_o  out  1,1  registered predictor update (to branch_i, jump_i)
- bp_pc_o, bp_target_o  out  32,32  registered predictor update (to branch_pc_i, target_pc_i)
- branch_cnt_o, mispred_cnt_o  out  32,32  performance counters
- err_o  out  1  sticky protocol error

## Operation
- full = (count == FIFO_DEPTH), using the registered count. A pop in the same cycle does not relieve full.
- advance = !hold_i & !full & !flush_o. fetch_valid_o = advance.
- Head entry = {pc, taken, ppc}. pred_next = taken ? ppc : pc+4. act_next = ex_jump_i ? ex_target_i : ex_pc_i+4. All sums are 32-bit modulo.
- mispredict = ex_valid_i & !empty & ((pred_next != act_next) | (head.pc != ex_pc_i)). flush_o = mispredict.
- A non-branch instruction that was predicted taken (predictor aliasing) is a mispredict, redirected to ex_pc_i+4.
- Next PC, in priority order:
  - mispredict → act_next
  - advance → (pred_taken_i ? {pred_pc_i[31:2],2'b00} : pc_o+4)
  - otherwise hold
- Push {pc_o, pred_taken_i, pred_pc_i} when advance.
- Pop head when ex_valid_i & !empty. Push and pop in the same cycle leaves count unchanged.
- On mispredict, the FIFO is cleared: count=0, pointers reset, and no push that cycle. Redirect overrides hold_i.
- ex_valid_i with an empty FIFO is ignored and sets err_o. err_o clears only on reset.
- Predictor update: when ex_valid_i & ex_branch_i & !empty, the next cycle shows bp_branch_o=1 with bp_jump_o=ex_jump_i, bp_pc_o=ex_pc_i, bp_target_o=ex_target_i. Otherwise bp_branch_o=0 and the data fields hold their last value.
- branch_cnt_o increments on every counted update. mispred_cnt_o increments on every mispredict. Both wrap 2^32-1→0.

## Timing
- Reset values: pc_o=RESET_PC, FIFO empty, bp_* all 0, counters 0, err_o=0. fetch_valid_o = !hold_i. flush_o=0 because the FIFO is empty.
- Prediction to PC: one cycle. pred_* in cycle T appears as pc_o in T+1.
- Redirect: mispredict in T → flush_o=1 in T, pc_o=act_next in T+1, and fetch_valid_o in T is 0.
- Update latency: one cycle after resolution.
- Reset asserted mid-operation clears state immediately. First fetch after release is RESET_PC.
- Full FIFO: pc_o holds and fetch_valid_o=0 until a pop lowers count; fetch resumes the cycle after.

## Test plan
- Reset, no stalls, pred_taken_i=0: pc_o runs 0,4,8,C; fetch_valid_o=1; FIFO reaches 4 → pc_o holds at 0x10 and fetch_valid_o=0 until ex_valid_i pops.
- Taken prediction: at pc_o=0x8 drive pred_taken_i=1, pred_pc_i=0x41 → next pc_o=0x40; resolve ex_pc_i=0x8, jump=1, target=0x40 → flush_o=0, bp_branch_o=1 next cycle, branch_cnt_o=1.
- Mispredict: predicted not-taken at 0x8, resolved jump to 0x100 → flush_o=1 that cycle, pc_o=0x100 next, FIFO empty, mispred_cnt_o=1, hold_i=1 does not block the redirect.
- Aliasing: non-branch at 0xC predicted taken to 0x80, resolved ex_branch_i=0 → flush_o=1, pc_o=0x10, bp_branch_o stays 0.
- Underflow: ex_valid_i with an empty FIFO → no flush, no counter change, err_o=1 and sticky.
- Reset mid-run: assert rst=0 with 3 entries queued and bp_branch_o=1 → all outputs return to reset values asynchronously; after release pc_o=RESET_PC.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen
//   Fetch-stage PC generator. Owns the architectural fetch PC, drives the
//   branch predictor lookup, keeps an in-order FIFO of the predictions made
//   for in-flight instructions and checks each against the outcome resolved
//   in execute. A mismatch flushes IF/ID and redirects fetch. A registered
//   update stream trains the predictor.
//
// Parameters
//   RESET_PC    fetch PC after reset (word aligned)
//   FIFO_DEPTH  in-flight prediction entries (power of two, 2..16)
//
// Ports
//   clk, rst                    clock, asynchronous active-low reset
//   hold_i                      downstream stall
//   pc_o                        current fetch PC
//   pred_taken_i, pred_pc_i     predictor lookup result for pc_o (same cycle)
//   fetch_valid_o               instruction at pc_o accepted this cycle
//   ex_valid_i .. ex_target_i   one resolved instruction per cycle, in order
//   flush_o                     squash IF/ID this cycle (combinational)
//   bp_branch_o .. bp_target_o  registered predictor update
//   branch_cnt_o, mispred_cnt_o performance counters (wrapping)
//   err_o                       sticky: resolve seen with an empty FIFO
//
// Handshake: fetch_valid_o is the push strobe into the pipe; there is no
// back-pressure other than hold_i, a full prediction FIFO, or a flush.
// ex_valid_i is a one-cycle strobe per resolved instruction and is always
// consumed in the cycle it is asserted.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_i,
  output logic [31:0] pc_o,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_pc_i,
  output logic        fetch_valid_o,
  input  logic        ex_valid_i,
  input  logic        ex_branch_i,
  input  logic        ex_jump_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_target_i,
  output logic        flush_o,
  output logic        bp_branch_o,
  output logic        bp_jump_o,
  output logic [31:0] bp_pc_o,
  output logic [31:0] bp_target_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispred_cnt_o,
  output logic        err_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  // Prediction FIFO storage. Contents need no reset: count gates every read.
  logic [31:0] fifo_pc    [FIFO_DEPTH];
  logic        fifo_taken [FIFO_DEPTH];
  logic [31:0] fifo_ppc   [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          empty;
  logic          full;
  logic          advance;
  logic          push;
  logic          pop;
  logic          mispredict;
  logic          update;

  logic [31:0]   pred_target;
  logic [31:0]   head_pc;
  logic          head_taken;
  logic [31:0]   head_ppc;
  logic [31:0]   pred_next;
  logic [31:0]   act_next;
  logic [31:0]   pc_next;

  // Predictor target with the byte offset dropped.
  assign pred_target = pred_pc_i & ~32'h0000_0003;

  // Full uses the registered count, so a same-cycle pop does not unblock
  // fetch; fetch resumes the cycle after the pop.
  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  assign head_pc    = fifo_pc[rd_ptr];
  assign head_taken = fifo_taken[rd_ptr];
  assign head_ppc   = fifo_ppc[rd_ptr];

  assign pred_next = head_taken ? head_ppc : (head_pc + 32'd4);
  assign act_next  = ex_jump_i ? ex_target_i : (ex_pc_i + 32'd4);

  // A predicted-taken non-branch (predictor aliasing) falls out naturally:
  // act_next is ex_pc_i+4 while pred_next is the aliased target.
  assign pop        = ex_valid_i & ~empty;
  assign mispredict = pop & ((pred_next != act_next) | (head_pc != ex_pc_i));
  assign update     = pop & ex_branch_i;

  assign flush_o       = mispredict;
  assign advance       = ~hold_i & ~full & ~mispredict;
  assign fetch_valid_o = advance;
  assign push          = advance;

  // Redirect has priority and overrides hold_i.
  always_comb begin
    pc_next = pc_o;
    if (mispredict) begin
      pc_next = act_next;
    end else if (advance) begin
      pc_next = pred_taken_i ? pred_target : (pc_o + 32'd4);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_o <= RESET_PC;
    end else begin
      pc_o <= pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= pc_o;
      fifo_taken[wr_ptr] <= pred_taken_i;
      fifo_ppc[wr_ptr]   <= pred_target;
    end
  end

  // A mispredict discards every younger prediction; push is already
  // suppressed that cycle because advance depends on it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (mispredict) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Predictor training stream: the strobe pulses for one cycle, the data
  // fields keep their last value between updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bp_branch_o <= 1'b0;
      bp_jump_o   <= 1'b0;
      bp_pc_o     <= '0;
      bp_target_o <= '0;
    end else begin
      bp_branch_o <= update;
      if (update) begin
        bp_jump_o   <= ex_jump_i;
        bp_pc_o     <= ex_pc_i;
        bp_target_o <= ex_target_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else begin
      if (update) begin
        branch_cnt_o <= branch_cnt_o + 32'd1;
      end
      if (mispredict) begin
        mispred_cnt_o <= mispred_cnt_o + 32'd1;
      end
    end
  end

  // A resolve with nothing in flight means the pipe and the FIFO disagree.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_o <= 1'b0;
    end else if (ex_valid_i && empty) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed testbench for fetch_pc_gen. Inputs change on the falling edge,
// outputs are checked just after, away from the rising edge.
module tb_fetch_pc_gen;

  logic        clk;
  logic        rst;
  logic        hold_i;
  logic [31:0] pc_o;
  logic        pred_taken_i;
  logic [31:0] pred_pc_i;
  logic        fetch_valid_o;
  logic        ex_valid_i;
  logic        ex_branch_i;
  logic        ex_jump_i;
  logic [31:0] ex_pc_i;
  logic [31:0] ex_target_i;
  logic        flush_o;
  logic        bp_branch_o;
  logic        bp_jump_o;
  logic [31:0] bp_pc_o;
  logic [31:0] bp_target_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispred_cnt_o;
  logic        err_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];

  fetch_pc_gen #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .hold_i        (hold_i),
    .pc_o          (pc_o),
    .pred_taken_i  (pred_taken_i),
    .pred_pc_i     (pred_pc_i),
    .fetch_valid_o (fetch_valid_o),
    .ex_valid_i    (ex_valid_i),
    .ex_branch_i   (ex_branch_i),
    .ex_jump_i     (ex_jump_i),
    .ex_pc_i       (ex_pc_i),
    .ex_target_i   (ex_target_i),
    .flush_o       (flush_o),
    .bp_branch_o   (bp_branch_o),
    .bp_jump_o     (bp_jump_o),
    .bp_pc_o       (bp_pc_o),
    .bp_target_o   (bp_target_o),
    .branch_cnt_o  (branch_cnt_o),
    .mispred_cnt_o (mispred_cnt_o),
    .err_o         (err_o)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic br, input logic jp,
                        input logic [31:0] pc, input logic [31:0] tgt);
    ex_valid_i  = v;
    ex_branch_i = br;
    ex_jump_i   = jp;
    ex_pc_i     = pc;
    ex_target_i = tgt;
    #1;
  endtask

  task automatic clear_inputs();
    hold_i       = 1'b0;
    pred_taken_i = 1'b0;
    pred_pc_i    = '0;
    ex_valid_i   = 1'b0;
    ex_branch_i  = 1'b0;
    ex_jump_i    = 1'b0;
    ex_pc_i      = '0;
    ex_target_i  = '0;
  endtask

  // Leaves the bench at a falling edge, reset released, pc_o = RESET_PC.
  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();

    // Reset state
    @(negedge clk);
    #1;
    check("rst_pc", pc_o, 32'h0);
    check("rst_fv", 32'(fetch_valid_o), 32'd1);
    check("rst_flush", 32'(flush_o), 32'd0);
    check("rst_bp_branch", 32'(bp_branch_o), 32'd0);
    check("rst_bp_pc", bp_pc_o, 32'h0);
    check("rst_bp_target", bp_target_o, 32'h0);
    check("rst_branch_cnt", branch_cnt_o, 32'd0);
    check("rst_mispred_cnt", mispred_cnt_o, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    hold_i = 1'b1;
    #1;
    check("rst_fv_hold", 32'(fetch_valid_o), 32'd0);
    hold_i = 1'b0;

    // Sequential fetch, FIFO fills after four pushes
    do_reset();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    for (int i = 0; i < 4; i++) begin
      check("seq_pc", pc_o, exp_q.pop_front());
      check("seq_fv", 32'(fetch_valid_o), 32'd1);
      step();
    end
    check("full_pc", pc_o, 32'h10);
    check("full_fv", 32'(fetch_valid_o), 32'd0);
    step();
    check("full_pc_hold", pc_o, 32'h10);
    check("full_fv_hold", 32'(fetch_valid_o), 32'd0);
    set_ex(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("full_pop_flush", 32'(flush_o), 32'd0);
    check("full_pop_fv", 32'(fetch_valid_o), 32'd0);
    step();
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("resume_fv", 32'(fetch_valid_o), 32'd1);
    check("resume_pc", pc_o, 32'h10);
    step();
    check("resume_pc_next", pc_o, 32'h14);

    // Correct taken prediction
    do_reset();
    step();
    step();
    check("tk_pc8", pc_o, 32'h8);
    pred_taken_i = 1'b1;
    pred_pc_i    = 32'h41;
    #1;
    check("tk_fv", 32'(fetch_valid_o), 32'd1);
    step();
    pred_taken_i = 1'b0;
    pred_pc_i    = '0;
    hold_i       = 1'b1;
    #1;
    check("tk_target_pc", pc_o, 32'h40);
    set_ex(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("tk_res0_flush", 32'(flush_o), 32'd0);
    step();
    set_ex(1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    check("tk_res4_flush", 32'(flush_o), 32'd0);
    step();
    set_ex(1'b1, 1'b1, 1'b1, 32'h8, 32'h40);
    check("tk_res8_flush", 32'(flush_o), 32'd0);
    step();
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("tk_bp_branch", 32'(bp_branch_o), 32'd1);
    check("tk_bp_jump", 32'(bp_jump_o), 32'd1);
    check("tk_bp_pc", bp_pc_o, 32'h8);
    check("tk_bp_target", bp_target_o, 32'h40);
    check("tk_branch_cnt", branch_cnt_o, 32'd1);
    check("tk_mispred_cnt", mispred_cnt_o, 32'd0);
    check("tk_pc_held", pc_o, 32'h40);
    step();
    check("tk_bp_branch_drop", 32'(bp_branch_o), 32'd0);
    check("tk_bp_pc_keep", bp_pc_o, 32'h8);

    // Mispredict, redirect beats hold_i
    do_reset();
    step();
    step();
    step();
    check("mp_pc_c", pc_o, 32'hC);
    hold_i = 1'b1;
    set_ex(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    set_ex(1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    step();
    set_ex(1'b1, 1'b1, 1'b1, 32'h8, 32'h100);
    check("mp_flush", 32'(flush_o), 32'd1);
    check("mp_fv", 32'(fetch_valid_o), 32'd0);
    step();
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("mp_flush_drop", 32'(flush_o), 32'd0);
    check("mp_redirect_pc", pc_o, 32'h100);
    check("mp_mispred_cnt", mispred_cnt_o, 32'd1);
    check("mp_branch_cnt", branch_cnt_o, 32'd1);
    check("mp_bp_target", bp_target_o, 32'h100);
    // FIFO was cleared: exactly four more pushes fit before it is full
    hold_i = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("mp_refill_fv", 32'(fetch_valid_o), 32'd1);
      step();
    end
    check("mp_refill_full_fv", 32'(fetch_valid_o), 32'd0);
    check("mp_refill_pc", pc_o, 32'h110);

    // Aliasing: non-branch predicted taken
    do_reset();
    step();
    step();
    step();
    pred_taken_i = 1'b1;
    pred_pc_i    = 32'h80;
    #1;
    check("al_pc_c", pc_o, 32'hC);
    step();
    pred_taken_i = 1'b0;
    pred_pc_i    = '0;
    hold_i       = 1'b1;
    #1;
    check("al_pc_80", pc_o, 32'h80);
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, 1'b0, 1'b0, 32'(4 * i), 32'h0);
      check("al_seq_flush", 32'(flush_o), 32'd0);
      step();
    end
    set_ex(1'b1, 1'b0, 1'b0, 32'hC, 32'h0);
    check("al_flush", 32'(flush_o), 32'd1);
    step();
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("al_pc_10", pc_o, 32'h10);
    check("al_bp_branch", 32'(bp_branch_o), 32'd0);
    check("al_mispred_cnt", mispred_cnt_o, 32'd1);
    check("al_branch_cnt", branch_cnt_o, 32'd0);

    // Underflow
    do_reset();
    hold_i = 1'b1;
    set_ex(1'b1, 1'b1, 1'b1, 32'h20, 32'h200);
    check("uf_flush", 32'(flush_o), 32'd0);
    step();
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("uf_err", 32'(err_o), 32'd1);
    check("uf_pc", pc_o, 32'h0);
    check("uf_bp_branch", 32'(bp_branch_o), 32'd0);
    check("uf_branch_cnt", branch_cnt_o, 32'd0);
    check("uf_mispred_cnt", mispred_cnt_o, 32'd0);
    step();
    step();
    check("uf_err_sticky", 32'(err_o), 32'd1);

    // Reset mid-run
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
    end
    set_ex(1'b1, 1'b1, 1'b0, 32'h0, 32'h55);
    check("mr_pop_flush", 32'(flush_o), 32'd0);
    step();
    set_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    hold_i = 1'b1;
    #1;
    check("mr_bp_branch", 32'(bp_branch_o), 32'd1);
    check("mr_branch_cnt", branch_cnt_o, 32'd1);
    check("mr_pc", pc_o, 32'h10);
    rst = 1'b0;
    #1;
    check("mr_async_pc", pc_o, 32'h0);
    check("mr_async_bp_branch", 32'(bp_branch_o), 32'd0);
    check("mr_async_bp_target", bp_target_o, 32'h0);
    check("mr_async_branch_cnt", branch_cnt_o, 32'd0);
    @(negedge clk);
    rst    = 1'b1;
    hold_i = 1'b0;
    #1;
    check("mr_release_pc", pc_o, 32'h0);
    check("mr_release_fv", 32'(fetch_valid_o), 32'd1);
    step();
    check("mr_release_pc_next", pc_o, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
